bwt_rle_reader: RTL and testbench

Downstream consumer of the bwt core. Once the core raises done_flag, this block sweeps the core's read address from length-1 down to 0, which is the core's output order. It compresses the character stream into (symbol, run-count) pairs and presents them on a valid/ready output port for the next compression stage. It owns the core's adr bus while en is low; the top level muxes adr between the loader and this block.

---
 rtl/bwt_pkg.sv | 23 ++
 rtl/bwt_rle_reader.sv | 181 ++++++++++++++++++
 tb/tb_bwt_rle_reader.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bwt_pkg.sv
// ---------------------------------------------------------------------------
// bwt_pkg
// Shared definitions for the BWT core and its downstream run-length reader.
//   CHAR_W      : width of one character
//   ADDR_W      : width of the core address / length bus
//   MAX_LEN     : largest string the core can hold
//   rle_state_t : sequencing states of the run-length reader
// ---------------------------------------------------------------------------
package bwt_pkg;

    localparam int CHAR_W  = 8;
    localparam int ADDR_W  = 10;
    localparam int MAX_LEN = 1023;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        FLUSH     = 3'd2,
        WAIT_LAST = 3'd3,
        DONE      = 3'd4
    } rle_state_t;

endpackage : bwt_pkg

// File: rtl/bwt_rle_reader.sv
// ---------------------------------------------------------------------------
// bwt_rle_reader
// Reads the transformed string out of the BWT core once it signals
// completion and run-length encodes it into (symbol, count) pairs.
//
// The core presents its output in descending address order, so the reader
// sweeps adr from length-1 down to 0, consuming one character per cycle
// whenever the single-entry output slot can accept a new pair.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   done_flag  : core finished (level); its rising edge starts a sweep
//   length     : number of characters held in the core
//   adr        : read address driven to the core
//   bwt_char   : core character at adr, valid in the same cycle
//   out_sym    : run symbol
//   out_cnt    : run length, 1..MAX_RUN
//   out_valid  : pair available
//   out_ready  : downstream accepts the pair
//   out_last   : marks the final pair of the string
//   busy       : high from trigger until the sweep is complete
//   done       : one-cycle pulse when sweep and flush are complete
// ---------------------------------------------------------------------------
module bwt_rle_reader #(
    parameter int CHAR_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 8,
    parameter int MAX_RUN = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done_flag,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] adr,
    input  logic [CHAR_W-1:0] bwt_char,
    output logic [CHAR_W-1:0] out_sym,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    import bwt_pkg::rle_state_t;
    import bwt_pkg::IDLE;
    import bwt_pkg::RUN;
    import bwt_pkg::FLUSH;
    import bwt_pkg::WAIT_LAST;
    import bwt_pkg::DONE;

    localparam logic [CNT_W-1:0]  MAX_RUN_C = CNT_W'(MAX_RUN);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADR_ONE   = ADDR_W'(1);

    rle_state_t        state;
    logic              flag_q;      // done_flag from the previous cycle
    logic [ADDR_W-1:0] remaining;   // characters still to consume; latched length at trigger
    logic [CHAR_W-1:0] run_sym;
    logic [CNT_W-1:0]  run_cnt;     // 0 means no open run

    logic trigger;
    logic slot_free;
    logic handshake;

    // A character extends the open run only while the count can still grow;
    // a run that has reached MAX_RUN is closed even if the symbol repeats.
    function automatic logic extends_run(
        input logic [CHAR_W-1:0] c,
        input logic [CHAR_W-1:0] sym,
        input logic [CNT_W-1:0]  cnt
    );
        return (c == sym) && (cnt < MAX_RUN_C);
    endfunction

    assign trigger   = done_flag && !flag_q;
    assign handshake = out_valid && out_ready;
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flag_q    <= 1'b0;
            remaining <= '0;
            adr       <= '0;
            run_sym   <= '0;
            run_cnt   <= '0;
            out_sym   <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            flag_q <= done_flag;
            done   <= 1'b0;

            // Accepted pair leaves the slot; a reload below in the same
            // cycle overrides this so no pair is lost or duplicated.
            if (handshake) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        remaining <= length;
                        run_cnt   <= '0;
                        busy      <= 1'b1;
                        if (length == '0) begin
                            adr   <= '0;
                            state <= DONE;
                        end else begin
                            adr   <= length - ADR_ONE;
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    // Stalling holds adr, remaining and the open run intact.
                    if (slot_free) begin
                        if (run_cnt == '0) begin
                            run_sym <= bwt_char;
                            run_cnt <= CNT_ONE;
                        end else if (extends_run(bwt_char, run_sym, run_cnt)) begin
                            run_cnt <= run_cnt + CNT_ONE;
                        end else begin
                            out_sym   <= run_sym;
                            out_cnt   <= run_cnt;
                            out_last  <= 1'b0;
                            out_valid <= 1'b1;
                            run_sym   <= bwt_char;
                            run_cnt   <= CNT_ONE;
                        end

                        remaining <= remaining - ADR_ONE;
                        // Address 0 is the final character; hold there rather
                        // than wrapping to the top of the address space.
                        if (remaining > ADR_ONE) begin
                            adr <= adr - ADR_ONE;
                        end else begin
                            state <= FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    if (slot_free) begin
                        out_sym   <= run_sym;
                        out_cnt   <= run_cnt;
                        out_last  <= 1'b1;
                        out_valid <= 1'b1;
                        run_cnt   <= '0;
                        state     <= WAIT_LAST;
                    end
                end

                WAIT_LAST: begin
                    if (handshake) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    adr   <= '0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : bwt_rle_reader

// File: tb/tb_bwt_rle_reader.sv
// ---------------------------------------------------------------------------
// tb_bwt_rle_reader
// Directed bench for the BWT run-length reader. A character array stands in
// for the core (combinational read at adr). Expected pairs come from a
// run-length model of the string in read order; one negedge process checks
// every accepted pair, slot stability under back-pressure and address range.
// ---------------------------------------------------------------------------
module tb_bwt_rle_reader;

    localparam int CW = 8;
    localparam int AW = 10;
    localparam int NW = 8;
    localparam int MR = 255;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          done_flag = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] length    = '0;
    logic [AW-1:0] adr;
    logic [CW-1:0] bwt_char;
    logic [CW-1:0] out_sym;
    logic [NW-1:0] out_cnt;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [CW-1:0] mem [0:1023];
    assign bwt_char = mem[adr];

    typedef struct packed {
        logic [CW-1:0] sym;
        logic [NW-1:0] cnt;
        logic          last;
    } pair_t;

    pair_t exp_q[$];
    int    tests     = 0;
    int    fails     = 0;
    int    sum_cnt   = 0;
    int    busy_cnt  = 0;
    int    valid_cnt = 0;
    int    len_cur   = 0;

    bwt_rle_reader #(
        .CHAR_W (CW),
        .ADDR_W (AW),
        .CNT_W  (NW),
        .MAX_RUN(MR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .done_flag(done_flag),
        .length   (length),
        .adr      (adr),
        .bwt_char (bwt_char),
        .out_sym  (out_sym),
        .out_cnt  (out_cnt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Run-length encode the string in core output order (adr n-1 down to 0).
    function automatic void build_model(input int n);
        logic [CW-1:0] s[$];
        int i;
        int c;
        pair_t p;
        exp_q.delete();
        for (int a = n - 1; a >= 0; a--) s.push_back(mem[a]);
        i = 0;
        while (i < n) begin
            c = 1;
            while (i + c < n && s[i + c] == s[i] && c < MR) c++;
            p.sym  = s[i];
            p.cnt  = NW'(c);
            p.last = (i + c == n);
            exp_q.push_back(p);
            i += c;
        end
    endfunction

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) mem[s.len() - 1 - i] = s[i];
    endtask

    // Compare process
    logic          prev_hold = 1'b0;
    logic          prev_busy = 1'b0;
    logic [AW-1:0] prev_adr  = '0;
    logic [CW-1:0] h_sym;
    logic [NW-1:0] h_cnt;
    logic          h_last;
    pair_t         got_p;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (out_valid) valid_cnt++;
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sym", out_sym, h_sym);
                chk("hold_cnt", out_cnt, h_cnt);
                chk("hold_last", out_last, h_last);
            end
            if (busy && prev_busy) chk("adr_no_wrap", adr <= prev_adr, 1);
            if (busy && len_cur > 0) chk("adr_in_range", int'(adr) < len_cur, 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pair", out_valid, 0);
                end else begin
                    got_p = exp_q.pop_front();
                    chk("pair_sym", out_sym, got_p.sym);
                    chk("pair_cnt", out_cnt, got_p.cnt);
                    chk("pair_last", out_last, got_p.last);
                    sum_cnt += int'(out_cnt);
                end
            end
            prev_hold = out_valid && !out_ready;
            h_sym     = out_sym;
            h_cnt     = out_cnt;
            h_last    = out_last;
            prev_busy = busy;
            prev_adr  = adr;
        end
    end

    // One sweep: k returns the cycles from the trigger edge to the done pulse.
    task automatic run_case(input int n, input int stall, output int k);
        bit stalled;
        logic [AW-1:0] a_hold;
        done_flag = 1'b0;
        @(posedge clk); #1;
        build_model(n);
        len_cur   = n;
        sum_cnt   = 0;
        busy_cnt  = 0;
        valid_cnt = 0;
        length    = AW'(n);
        done_flag = 1'b1;
        @(posedge clk); #1;
        chk("busy_on_trigger", busy, 1);
        length  = AW'(n ^ 5);
        k       = 0;
        stalled = 1'b0;
        while (k < 2000) begin
            @(posedge clk); #1;
            k++;
            if (done) break;
            if (stall > 0 && !stalled && out_valid) begin
                out_ready = 1'b0;
                a_hold    = adr;
                for (int s = 0; s < stall; s++) begin
                    @(posedge clk); #1;
                    k++;
                    chk("stall_adr", adr, a_hold);
                    chk("stall_valid", out_valid, 1);
                end
                out_ready = 1'b1;
                stalled   = 1'b1;
            end
        end
        chk("done_seen", done, 1);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("busy_after", busy, 0);
        chk("adr_after", adr, 0);
        chk("pairs_left", exp_q.size(), 0);
        chk("count_sum", sum_cnt, n);
        chk("busy_cycles", busy_cnt, k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        // Reset state
        @(posedge clk); #1;
        chk("rst_adr", adr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sym", out_sym, 0);
        chk("rst_cnt", out_cnt, 0);
        rst_n = 1'b1;

        // 1: "aaabcc"
        load_str("aaabcc");
        build_model(6);
        chk("model1_n", exp_q.size(), 3);
        chk("model1_p0", {exp_q[0].sym, exp_q[0].cnt, 7'd0, exp_q[0].last}, {8'h61, 8'd3, 8'd0});
        chk("model1_p1", {exp_q[1].sym, exp_q[1].cnt, 7'd0, exp_q[1].last}, {8'h62, 8'd1, 8'd0});
        chk("model1_p2", {exp_q[2].sym, exp_q[2].cnt, 7'd0, exp_q[2].last}, {8'h63, 8'd2, 8'd1});
        run_case(6, 0, k);
        chk("t1_latency", k, 9);

        // 2: 300 x 'x' -> (x,255),(x,45,last)
        for (int i = 0; i < 300; i++) mem[i] = "x";
        build_model(300);
        chk("model2_n", exp_q.size(), 2);
        chk("model2_c0", exp_q[0].cnt, 255);
        chk("model2_c1", exp_q[1].cnt, 45);
        chk("model2_last", exp_q[1].last, 1);
        run_case(300, 0, k);
        chk("t2_latency", k, 303);

        // 3: case 1 with 5 cycles of back-pressure on (a,3)
        load_str("aaabcc");
        run_case(6, 5, k);
        chk("t3_latency", k, 14);

        // 4: empty string
        run_case(0, 0, k);
        chk("t4_latency", k, 1);
        chk("t4_no_valid", valid_cnt, 0);

        // 5: single 'z', done_flag then held high
        load_str("z");
        build_model(1);
        chk("model5_p0", {exp_q[0].sym, exp_q[0].cnt, 7'd0, exp_q[0].last}, {8'h7a, 8'd1, 8'd1});
        run_case(1, 0, k);
        chk("t5_latency", k, 4);
        busy_cnt  = 0;
        valid_cnt = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_retrigger_busy", busy_cnt, 0);
        chk("t5_no_retrigger_valid", valid_cnt, 0);
        done_flag = 1'b0;

        // 6: reset in the middle of the 300-character sweep
        for (int i = 0; i < 300; i++) mem[i] = "x";
        build_model(300);
        len_cur = 300;
        length  = AW'(300);
        @(posedge clk); #1;
        done_flag = 1'b1;
        repeat (50) @(posedge clk);
        #3;
        chk("t6_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_adr", adr, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_sym", out_sym, 0);
        chk("t6_rst_cnt", out_cnt, 0);
        chk("t6_rst_last", out_last, 0);
        chk("t6_rst_done", done, 0);
        exp_q.delete();
        done_flag = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_str("aaabcc");
        run_case(6, 0, k);
        chk("t6_rerun_latency", k, 9);
        done_flag = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_bwt_rle_reader
